// File: rtl/nios_multi_timer.sv
// nios_multi_timer: multi-channel Avalon-MM interval timer.
// NUM_CH independent 32-bit down-counters share one prescaler and one irq line.
// Optional feature macro: NIOS_MULTI_TIMER_PWM_EN (per-channel COMPARE reg + PWM output).
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   address        {channel, reg[2:0]}
//   chipselect     slave select
//   write_n        active-low write strobe
//   writedata      write data
//   readdata       registered read data, 1-cycle latency
//   irq            OR over channels of (TO & ITO)
//   pwm_out        per-channel PWM (0 when the PWM feature is not built)
module nios_multi_timer #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CH_BITS        = 2,
    parameter logic [31:0] DEFAULT_PERIOD = 32'hC34F,
    parameter int unsigned PRESCALE       = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CH_BITS+2:0]  address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic                irq,
    output logic [NUM_CH-1:0]   pwm_out
);
    localparam int unsigned NSLOT = 1 << CH_BITS;
    localparam int unsigned PW    = 16;
    localparam int unsigned DW    = 32;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);

    typedef logic [NUM_CH-1:0][DW-1:0] word_vec_t;

    logic [PW-1:0]      presc_q, presc_d;
    logic               tick_c;
    logic               wr_c;
    logic [CH_BITS-1:0] ch_c;
    logic [2:0]         reg_c;
    logic [NUM_CH-1:0]  wr_status_c, wr_ctrl_c, wr_period_c, wr_snap_c, expire_c;
    word_vec_t          cnt_q, cnt_d, period_q, period_d, snap_q, snap_d;
    logic [NUM_CH-1:0]  run_q, run_d, to_q, to_d, ito_q, ito_d, cont_q, cont_d;
    logic [NUM_CH-1:0]  reload_q, reload_d;
    logic [DW-1:0]      readdata_q, readdata_d;
    logic [DW-1:0]      rd_slot_c [NSLOT];
`ifdef NIOS_MULTI_TIMER_PWM_EN
    logic [NUM_CH-1:0]  wr_cmp_c;
    word_vec_t          compare_q, compare_d;
    logic [NUM_CH-1:0]  pwm_q, pwm_d;
`endif

    // Shared prescaler: tick in the cycle the phase counter reaches PRESCALE-1.
    always_comb begin
        tick_c  = (presc_q == PRESCALE_LAST);
        presc_d = tick_c ? '0 : presc_q + PW'(1);
    end

    // Bus decode and per-channel timeout detect; a PERIOD write or pending reload blocks the timeout.
    always_comb begin
        wr_c        = chipselect & ~write_n;
        ch_c        = address[CH_BITS+2:3];
        reg_c       = address[2:0];
        wr_status_c = '0;
        wr_ctrl_c   = '0;
        wr_period_c = '0;
        wr_snap_c   = '0;
        expire_c    = '0;
`ifdef NIOS_MULTI_TIMER_PWM_EN
        wr_cmp_c    = '0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_c && (ch_c == CH_BITS'(i))) begin
                wr_status_c[i] = (reg_c == 3'd0);
                wr_ctrl_c[i]   = (reg_c == 3'd1);
                wr_period_c[i] = (reg_c == 3'd2);
                wr_snap_c[i]   = (reg_c == 3'd3);
`ifdef NIOS_MULTI_TIMER_PWM_EN
                wr_cmp_c[i]    = (reg_c == 3'd4);
`endif
            end
            expire_c[i] = run_q[i] & tick_c & (cnt_q[i] == '0) & ~reload_q[i] & ~wr_period_c[i];
        end
    end

    // Per-channel next state.
    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        snap_d   = snap_q;
        run_d    = run_q;
        to_d     = to_q;
        ito_d    = ito_q;
        cont_d   = cont_q;
        reload_d = wr_period_c;
`ifdef NIOS_MULTI_TIMER_PWM_EN
        compare_d = compare_q;
        pwm_d     = '0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_period_c[i]) period_d[i] = writedata;
            if (wr_snap_c[i])   snap_d[i]   = cnt_q[i];

            if (reload_q[i])                 cnt_d[i] = period_q[i];
            else if (wr_period_c[i])         cnt_d[i] = cnt_q[i];
            else if (expire_c[i])            cnt_d[i] = period_q[i];
            else if (run_q[i] && tick_c)     cnt_d[i] = cnt_q[i] - DW'(1);

            if (wr_ctrl_c[i]) begin
                ito_d[i]  = writedata[0];
                cont_d[i] = writedata[1];
            end

            // Timeout set wins over a same-cycle STATUS clear.
            to_d[i] = expire_c[i] | (to_q[i] & ~wr_status_c[i]);

            // START beats STOP and the reload clear.
            if (expire_c[i])                                 run_d[i] = cont_q[i];
            if (reload_q[i] || (wr_ctrl_c[i] && writedata[3])) run_d[i] = 1'b0;
            if (wr_ctrl_c[i] && writedata[2])                run_d[i] = 1'b1;
`ifdef NIOS_MULTI_TIMER_PWM_EN
            if (wr_cmp_c[i]) compare_d[i] = writedata;
            pwm_d[i] = run_q[i] & (cnt_q[i] < compare_q[i]);
`endif
        end
    end

    // Read mux; unpopulated channel slots read 0.
    always_comb begin
        for (int s = 0; s < NSLOT; s++) rd_slot_c[s] = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (reg_c)
                3'd0:    rd_slot_c[i] = {30'b0, run_q[i], to_q[i]};
                3'd1:    rd_slot_c[i] = {30'b0, cont_q[i], ito_q[i]};
                3'd2:    rd_slot_c[i] = period_q[i];
                3'd3:    rd_slot_c[i] = snap_q[i];
`ifdef NIOS_MULTI_TIMER_PWM_EN
                3'd4:    rd_slot_c[i] = compare_q[i];
`endif
                default: rd_slot_c[i] = '0;
            endcase
        end
        readdata_d = rd_slot_c[ch_c];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q    <= '0;
            cnt_q      <= {NUM_CH{DEFAULT_PERIOD}};
            period_q   <= {NUM_CH{DEFAULT_PERIOD}};
            snap_q     <= '0;
            run_q      <= '0;
            to_q       <= '0;
            ito_q      <= '0;
            cont_q     <= '0;
            reload_q   <= '0;
            readdata_q <= '0;
        end else begin
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            snap_q     <= snap_d;
            run_q      <= run_d;
            to_q       <= to_d;
            ito_q      <= ito_d;
            cont_q     <= cont_d;
            reload_q   <= reload_d;
            readdata_q <= readdata_d;
        end
    end

`ifdef NIOS_MULTI_TIMER_PWM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            compare_q <= '0;
            pwm_q     <= '0;
        end else begin
            compare_q <= compare_d;
            pwm_q     <= pwm_d;
        end
    end
    assign pwm_out = pwm_q;
`else
    assign pwm_out = '0;
`endif

    assign readdata = readdata_q;
    assign irq      = |(to_q & ito_q);

endmodule
